// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: select codes,
// the per-stage shadow entry and the ready-stage lookup.
package fwd_pkg;

  localparam int FWD_RAW   = 8;  // widest supported register address
  localparam int FWD_SRC   = 4;  // most source operands per instruction
  localparam int FWD_STG_W = 4;  // stage index width (DEPTH up to 15)

  localparam logic [1:0] FU_SRC_REG = 2'd0;
  localparam logic [1:0] FU_SRC_MEM = 2'd1;
  localparam logic [1:0] FU_SRC_WB  = 2'd2;

  typedef struct packed {
    logic                             valid;
    logic [FWD_RAW-1:0]               rd;
    logic [FWD_STG_W-1:0]             ready_stage;
    logic [FWD_SRC-1:0][FWD_RAW-1:0]  rs;
    logic [FWD_SRC-1:0]               used;
  } shadow_t;

  function automatic logic [FWD_STG_W-1:0] ready_stage_of(input logic is_load,
                                                         input int   alu_ready,
                                                         input int   load_ready);
    return is_load ? FWD_STG_W'(load_ready) : FWD_STG_W'(alu_ready);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source priority encoder: nearest-stage bypass select for the EX operand
// and result-not-ready conflict flag for the ID operand.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [FWD_RAW-1:0]     ex_rs,
  input  logic                   ex_used,
  input  logic [FWD_RAW-1:0]     id_rs,
  input  logic                   id_used,
  input  shadow_t [DEPTH-1:0]    ent,
  output logic [SEL_W-1:0]       sel,
  output logic                   conflict
);

  logic unused_fields;

  always_comb begin
    sel      = SEL_W'(FU_SRC_REG);
    conflict = 1'b0;
    // Scan oldest to youngest so the nearest match is the one left standing.
    if (ex_used && ex_rs != '0) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (ent[k].valid && ent[k].rd == ex_rs) sel = SEL_W'(k);
      end
    end
    if (id_used && id_rs != '0) begin
      for (int s = 0; s <= DEPTH - 2; s++) begin
        if (ent[s].valid && ent[s].rd == id_rs &&
            (FWD_STG_W'(s + 1) < ent[s].ready_stage)) conflict = 1'b1;
      end
    end
  end

  always_comb begin
    unused_fields = ^ent[DEPTH-1].ready_stage;
    for (int k = 0; k < DEPTH; k++) begin
      unused_fields = unused_fields ^ (^{ent[k].rs, ent[k].used});
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadows in-flight destinations EX..WB, drives
// EX bypass selects, stalls ID on not-ready results and counts stall cycles.
module fwd_hazard_unit
#(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_rd_we_i,
  input  logic                      id_is_load_i,
  input  logic                      ex_busy_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SEL_W-1:0]  sel_src_o,
  output logic [31:0]               stall_cnt_o
);

  import fwd_pkg::*;

  shadow_t [DEPTH-1:0] ent_q;
  shadow_t             id_ent;
  logic [NUM_SRC-1:0]  conflict;
  logic                hazard;
  logic                issue;
  logic [31:0]         stall_cnt_q;

  assign hazard  = id_valid_i & (|conflict);
  assign issue   = id_valid_i & ~hazard & ~flush_i;
  assign stall_o = ex_busy_i | (hazard & ~flush_i);

  // x0 and non-writing instructions never match, so they enter as invalid.
  always_comb begin
    id_ent             = '0;
    id_ent.valid       = issue & id_rd_we_i & (id_rd_i != '0);
    id_ent.rd          = FWD_RAW'(id_rd_i);
    id_ent.ready_stage = ready_stage_of(id_is_load_i, ALU_READY, LOAD_READY);
    for (int j = 0; j < NUM_SRC; j++) begin
      id_ent.rs[j]   = FWD_RAW'(id_rs_i[j*REG_AW +: REG_AW]);
      id_ent.used[j] = issue & id_rs_used_i[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else if (!ex_busy_i) begin
      ent_q[0] <= id_ent;
      for (int k = 1; k < DEPTH; k++) ent_q[k] <= ent_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_o && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .ex_rs    (ent_q[0].rs[j]),
      .ex_used  (ent_q[0].used[j]),
      .id_rs    (FWD_RAW'(id_rs_i[j*REG_AW +: REG_AW])),
      .id_used  (id_rs_used_i[j]),
      .ent      (ent_q),
      .sel      (sel_src_o[j*SEL_W +: SEL_W]),
      .conflict (conflict[j])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default DEPTH=3 instance plus a
// DEPTH=4 / LOAD_READY=3 instance driven by the same ID stream.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic        ex_busy;
  logic        flush;

  logic        stall3, stall4;
  logic [3:0]  sel3, sel4;
  logic [31:0] cnt3, cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_rs_used), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we),
    .id_is_load_i(id_is_load), .ex_busy_i(ex_busy), .flush_i(flush),
    .stall_o(stall3), .sel_src_o(sel3), .stall_cnt_o(cnt3)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_READY(3)) dut4 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_rs_used), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we),
    .id_is_load_i(id_is_load), .ex_busy_i(ex_busy), .flush_i(flush),
    .stall_o(stall4), .sel_src_o(sel4), .stall_cnt_o(cnt4)
  );

  always @(posedge clk) begin
    if (!rst) assert (!(flush && ex_busy)) else $error("flush during ex_busy");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid   = v;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_rd_we   = we;
    id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_busy = 1'b0; flush = 1'b0;
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall3), 32'd0);
    chk("rst_sel",   32'(sel3),   32'd0);
    chk("rst_cnt",   cnt3,        32'd0);
    chk("rst_sel4",  32'(sel4),   32'd0);

    // 1: ALU back-to-back forwarding from MEM then WB
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    chk("t1_a_stall", 32'(stall3), 32'd0);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
    chk("t1_b_stall", 32'(stall3), 32'd0);
    tick();
    set_id(1'b1, 5'd3, 5'd5, 2'b11, 5'd7, 1'b1, 1'b0);
    chk("t1_b_sel", 32'(sel3), 32'h1);
    chk("t1_c_stall", 32'(stall3), 32'd0);
    tick();
    idle();
    chk("t1_c_sel", 32'(sel3), 32'h8);
    chk("t1_cnt", cnt3, 32'd0);

    // 2: load-use inserts one bubble, then forward from WB
    do_reset();
    set_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
    chk("t2_stall1", 32'(stall3), 32'd1);
    tick();
    chk("t2_stall2", 32'(stall3), 32'd0);
    chk("t2_bubble_sel", 32'(sel3), 32'h0);
    tick();
    idle();
    chk("t2_sel", 32'(sel3), 32'h2);
    chk("t2_cnt", cnt3, 32'd1);

    // 3: x0 never forwards; unused sources never match
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd4, 1'b1, 1'b0);
    chk("t3_x0_stall", 32'(stall3), 32'd0);
    tick();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 1'b1);
    chk("t3_x0_sel", 32'(sel3), 32'h0);
    tick();
    set_id(1'b1, 5'd9, 5'd3, 2'b10, 5'd10, 1'b1, 1'b0);
    chk("t3_unused_stall", 32'(stall3), 32'd0);
    tick();
    idle();
    chk("t3_unused_sel", 32'(sel3), 32'h0);

    // 4: multi-cycle EX freezes everything for 3 cycles
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd11, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
    ex_busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_busy_stall", 32'(stall3), 32'd1);
      chk("t4_busy_sel",   32'(sel3),   32'h1);
      tick();
    end
    ex_busy = 1'b0;
    #1;
    chk("t4_after_stall", 32'(stall3), 32'd0);
    chk("t4_frozen_sel", 32'(sel3), 32'h1);
    tick();
    idle();
    chk("t4_fwd_sel", 32'(sel3), 32'h1);
    chk("t4_cnt", cnt3, 32'd3);

    // 5: flush cancels a load-use stall
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd12, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    set_id(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0);
    chk("t5_flush_stall", 32'(stall3), 32'd0);
    tick();
    flush = 1'b0;
    idle();
    chk("t5_post_stall", 32'(stall3), 32'd0);
    chk("t5_bubble_sel", 32'(sel3), 32'h0);
    tick();
    chk("t5_cnt", cnt3, 32'd0);

    // 6a: DEPTH=4, LOAD_READY=3 -> two bubbles then forward from stage 3
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd13, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd13, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0);
    chk("t6_stall1", 32'(stall4), 32'd1);
    tick();
    chk("t6_stall2", 32'(stall4), 32'd1);
    tick();
    chk("t6_stall3", 32'(stall4), 32'd0);
    tick();
    idle();
    chk("t6_sel", 32'(sel4), 32'h3);
    chk("t6_cnt", cnt4, 32'd2);

    // 6b: asynchronous reset mid-stream
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd14, 5'd0, 2'b01, 5'd15, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd15, 5'd0, 2'b01, 5'd16, 1'b1, 1'b0);
    chk("t6_pre_stall", 32'(stall3), 32'd1);
    chk("t6_pre_sel", 32'(sel3), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", 32'(stall3), 32'd0);
    chk("t6_rst_sel",   32'(sel3),   32'h0);
    chk("t6_rst_cnt",   cnt3,        32'd0);
    chk("t6_rst_stall4", 32'(stall4), 32'd0);
    chk("t6_rst_cnt4",  cnt4,        32'd0);
    tick();
    rst = 1'b0;
    set_id(1'b1, 5'd14, 5'd0, 2'b01, 5'd17, 1'b1, 1'b0);
    tick();
    idle();
    chk("t6_first_sel", 32'(sel3), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
